// File: rtl/card_reader.sv
// Card front end: deserialises an MSB-first ID frame with even parity, checks it
// against VALID_ID and holds card_valid or card_invalid for a fixed window.
//
// state       | meaning
// ------------+----------------------------------------------------
// IDLE        | armed, waiting for the first strobe with a card present
// RECV        | shifting in ID and parity bits, watching the strobe gap
// CHECK       | one cycle: latch card_id, decide grant or deny
// GRANT       | card_valid held for HOLD_CYCLES cycles
// DENY        | card_invalid held for HOLD_CYCLES cycles
// WAIT_REMOVE | result delivered, waiting for the card to leave the slot
module card_reader #(
  parameter int                  ID_WIDTH    = 8,
  parameter logic [ID_WIDTH-1:0] VALID_ID    = 8'hA5,
  parameter int                  HOLD_CYCLES = 50,
  parameter int                  TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                card_present,
  input  logic                card_bit,
  input  logic                card_strobe,
  output logic                card_valid,
  output logic                card_invalid,
  output logic                busy,
  output logic [ID_WIDTH-1:0] card_id
);

  localparam int BIT_W  = $clog2(ID_WIDTH + 2);
  localparam int GAP_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    CHECK,
    GRANT,
    DENY,
    WAIT_REMOVE
  } state_t;

  state_t              state;
  logic [ID_WIDTH:0]   shreg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  // Outputs are updated alongside each transition so they track the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      hold_cnt     <= '0;
      card_valid   <= 1'b0;
      card_invalid <= 1'b0;
      busy         <= 1'b0;
      card_id      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (card_strobe && card_present) begin
            shreg   <= {shreg[ID_WIDTH-1:0], card_bit};
            bit_cnt <= BIT_W'(1);
            gap_cnt <= '0;
            busy    <= 1'b1;
            state   <= RECV;
          end
        end
        RECV: begin
          if (!card_present) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (card_strobe) begin
            shreg   <= {shreg[ID_WIDTH-1:0], card_bit};
            bit_cnt <= bit_cnt + BIT_W'(1);
            gap_cnt <= '0;
            if (bit_cnt == BIT_W'(ID_WIDTH)) state <= CHECK;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
            if (gap_cnt == GAP_W'(TIMEOUT - 1)) begin
              hold_cnt     <= HOLD_W'(HOLD_CYCLES - 1);
              card_invalid <= 1'b1;
              state        <= DENY;
            end
          end
        end
        CHECK: begin
          card_id  <= shreg[ID_WIDTH:1];
          hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
          if (!(^shreg) && shreg[ID_WIDTH:1] == VALID_ID) begin
            card_valid <= 1'b1;
            state      <= GRANT;
          end else begin
            card_invalid <= 1'b1;
            state        <= DENY;
          end
        end
        GRANT: begin
          if (hold_cnt == '0) begin
            card_valid <= 1'b0;
            state      <= WAIT_REMOVE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        DENY: begin
          if (hold_cnt == '0) begin
            card_invalid <= 1'b0;
            state        <= WAIT_REMOVE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        WAIT_REMOVE: begin
          if (!card_present) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          card_valid   <= 1'b0;
          card_invalid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_reader.sv
// Bench for card_reader: table of directed frames, random frames checked against
// a frame-level decision model, and hand-written timeout/abort/reset sequences.
module tb_card_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       card_present = 1'b0;
  logic       card_bit = 1'b0;
  logic       card_strobe = 1'b0;
  logic       card_valid;
  logic       card_invalid;
  logic       busy;
  logic [7:0] card_id;

  int n_checks = 0;
  int n_fail   = 0;

  card_reader dut (
    .clk          (clk),
    .reset        (reset),
    .card_present (card_present),
    .card_bit     (card_bit),
    .card_strobe  (card_strobe),
    .card_valid   (card_valid),
    .card_invalid (card_invalid),
    .busy         (busy),
    .card_id      (card_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] id;
    bit         bad_par;
    int         gap;
    bit         noise;
    bit         drop_mid;
    bit         exp_grant;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decision: grant only for an exact ID match with correct even parity.
  function automatic bit model_grant(input logic [7:0] id, input bit bad_par);
    return (id == 8'hA5) && !bad_par;
  endfunction

  // Sends the first n bits of an ID+parity frame, MSB first, gap idle cycles between bits.
  task automatic send_bits(input logic [8:0] frame, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      card_bit    = frame[8 - i];
      card_strobe = 1'b1;
      tick();
      card_strobe = 1'b0;
      card_bit    = 1'b0;
      if (i != 8)
        for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic run_frame(input logic [7:0] id, input bit bad_par, input int gap,
                           input bit noise, input bit drop_mid, input bit exp_grant,
                           input string tag);
    logic [8:0] frame;
    int         hi;
    int         other;
    int         overlap;
    bit         cur;
    frame = {id, (^id) ^ bad_par};
    card_present = 1'b1;
    tick();
    send_bits(frame, 9, gap);
    chk({tag, " check_cycle"}, {card_valid, card_invalid, busy}, 3'b001);
    tick();
    chk({tag, " valid_rise"}, card_valid, exp_grant);
    chk({tag, " invalid_rise"}, card_invalid, !exp_grant);
    chk({tag, " card_id"}, card_id, id);
    hi = 1; other = 0; overlap = 0;
    for (int c = 0; c < 80; c++) begin
      if (noise) begin
        card_strobe = 1'($urandom_range(0, 1));
        card_bit    = 1'($urandom_range(0, 1));
      end
      if (drop_mid && hi == 20) card_present = 1'b0;
      tick();
      cur = exp_grant ? card_valid : card_invalid;
      if (card_valid && card_invalid) overlap++;
      if (exp_grant ? card_invalid : card_valid) other++;
      if (!cur) break;
      hi++;
    end
    card_strobe = 1'b0;
    chk({tag, " hold_len"}, hi, 50);
    chk({tag, " other_out"}, other, 0);
    chk({tag, " exclusive"}, overlap, 0);
    chk({tag, " busy_wait"}, busy, 1'b1);
    if (drop_mid) begin
      tick();
      chk({tag, " busy_exit"}, busy, 1'b0);
    end else begin
      for (int s = 0; s < 3; s++) begin
        card_strobe = 1'b1;
        card_bit    = 1'($urandom_range(0, 1));
        tick();
      end
      card_strobe = 1'b0;
      chk({tag, " wait_ignores"}, {card_valid, card_invalid, busy}, 3'b001);
      card_present = 1'b0;
      chk({tag, " busy_before_exit"}, busy, 1'b1);
      tick();
      chk({tag, " busy_exit"}, busy, 1'b0);
    end
    card_present = 1'b0;
    tick();
  endtask

  initial begin
    logic [8:0] f;
    logic [7:0] rid;
    bit         rbad;
    int         rgap;

    vecs[0] = '{8'hA5, 1'b0, 0,  1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 0,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 0,  1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 15, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 2,  1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hA5, 1'b0, 1,  1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'hA4, 1'b0, 0,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 3,  1'b1, 1'b0, 1'b0};

    // Reset held with random inputs
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      card_present = 1'($urandom_range(0, 1));
      card_strobe  = 1'($urandom_range(0, 1));
      card_bit     = 1'($urandom_range(0, 1));
      tick();
      chk("reset_outputs", {card_valid, card_invalid, busy, card_id}, 11'd0);
    end
    card_present = 1'b0; card_strobe = 1'b0; card_bit = 1'b0;
    reset = 1'b0;
    tick();

    // Strobe without a card is ignored
    card_strobe = 1'b1;
    tick();
    card_strobe = 1'b0;
    chk("idle_no_card", busy, 1'b0);

    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].id, vecs[v].bad_par, vecs[v].gap, vecs[v].noise,
                vecs[v].drop_mid, vecs[v].exp_grant, $sformatf("vec%0d", v));

    for (int r = 0; r < 10; r++) begin
      rid  = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
      rbad = ($urandom_range(0, 3) == 0);
      rgap = $urandom_range(0, 8);
      run_frame(rid, rbad, rgap, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                model_grant(rid, rbad), $sformatf("rand%0d", r));
    end

    // Inter-strobe timeout after 4 bits
    rid = 8'hA5;
    f = {rid, ^rid};
    card_present = 1'b1;
    tick();
    send_bits(f, 4, 0);
    for (int g = 0; g < 15; g++) tick();
    chk("timeout_not_yet", {card_invalid, busy}, 2'b01);
    tick();
    chk("timeout_deny", {card_valid, card_invalid}, 2'b01);
    for (int c = 0; c < 49; c++) tick();
    chk("timeout_hold_end", card_invalid, 1'b1);
    tick();
    chk("timeout_hold_done", {card_invalid, busy}, 2'b01);
    card_present = 1'b0;
    tick();
    chk("timeout_exit", busy, 1'b0);

    // Card pulled mid-frame: silent return to IDLE
    card_present = 1'b1;
    tick();
    send_bits(f, 4, 0);
    chk("abort_busy", busy, 1'b1);
    card_present = 1'b0;
    tick();
    chk("abort_idle", {card_valid, card_invalid, busy}, 3'b000);
    for (int g = 0; g < 20; g++) tick();
    chk("abort_no_pulse", {card_valid, card_invalid, busy}, 3'b000);

    // Removal wins over a simultaneous strobe
    card_present = 1'b1;
    tick();
    send_bits(f, 3, 0);
    card_present = 1'b0;
    card_strobe  = 1'b1;
    tick();
    card_strobe  = 1'b0;
    chk("abort_priority", busy, 1'b0);

    // Async reset 10 cycles into GRANT
    card_present = 1'b1;
    tick();
    send_bits(f, 9, 0);
    tick();
    for (int c = 0; c < 9; c++) tick();
    chk("grant_before_reset", card_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", {card_valid, card_invalid, busy, card_id}, 11'd0);
    tick();
    tick();
    reset = 1'b0;
    card_present = 1'b0;
    tick();
    run_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b1, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
